// File: rtl/cache_mem_arb_pkg.sv
// Shared types and default line geometry
// for the I/D cache memory-bus arbiter.
package cache_mem_arb_pkg;

  localparam int unsigned WORDS_PER_LINE_DEF = 4;
  localparam int unsigned WORD_SEL_BITS_DEF  = 2;
  localparam int unsigned OFFSET_BITS_DEF    = 4;
  localparam int unsigned TIMEOUT_CYCLES_DEF = 256;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef enum logic {
    REQ_I = 1'b0,
    REQ_D = 1'b1
  } requester_e;

endpackage

// File: rtl/cache_mem_arbiter_if.sv
// Word-wide memory bus driven by the arbiter
// toward memory_interface (ctrl_mem_* side).
interface cache_mem_arbiter_if;

  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_resp_valid;

  modport master (
    output mem_req,
    output mem_we,
    output mem_addr,
    output mem_wdata,
    input  mem_rdata,
    input  mem_resp_valid
  );

  modport slave (
    input  mem_req,
    input  mem_we,
    input  mem_addr,
    input  mem_wdata,
    output mem_rdata,
    output mem_resp_valid
  );

endinterface

// File: rtl/cache_mem_arb_rr.sv
// Two-way round-robin picker, purely
// combinational; the parent keeps rr_last.
module cache_mem_arb_rr
  import cache_mem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  requester_e last,
  output logic       grant_valid,
  output requester_e grant_id
);

  // On a tie, favour whoever did not win last
  always_comb begin
    grant_valid = |req;
    grant_id    = REQ_I;
    unique case (1'b1)
      (req == 2'b11):
        grant_id = (last == REQ_I) ? REQ_D
                                   : REQ_I;
      (req == 2'b10):
        grant_id = REQ_D;
      default:
        grant_id = REQ_I;
    endcase
  end

endmodule

// File: rtl/cache_mem_arbiter.sv
// Line-transaction arbiter for the shared memory bus.
// Optional watchdog: CACHE_MEM_ARB_TIMEOUT_EN.
module cache_mem_arbiter
  import cache_mem_arb_pkg::*;
#(
  parameter int unsigned WORDS_PER_LINE = WORDS_PER_LINE_DEF,
  parameter int unsigned WORD_SEL_BITS  = WORD_SEL_BITS_DEF,
  parameter int unsigned OFFSET_BITS    = OFFSET_BITS_DEF,
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_req,
  input  logic                     i_we,
  input  logic [31:0]              i_addr,
  input  logic [31:0]              i_wdata,
  output logic [31:0]              i_rdata,
  output logic                     i_rvalid,
  output logic                     i_done,
  output logic                     i_err,
  input  logic                     d_req,
  input  logic                     d_we,
  input  logic [31:0]              d_addr,
  input  logic [31:0]              d_wdata,
  output logic [31:0]              d_rdata,
  output logic                     d_rvalid,
  output logic                     d_done,
  output logic                     d_err,
  output logic [WORD_SEL_BITS-1:0] word_idx,
  cache_mem_arbiter_if.master      mem
);

  localparam int unsigned LW = 32 - OFFSET_BITS;

  state_e                   state_q, state_d;
  requester_e               owner_q, owner_d;
  requester_e               rr_last_q, rr_last_d;
  logic [WORD_SEL_BITS-1:0] widx_q, widx_d;
  logic [LW-1:0]            line_q, line_d;
  logic                     we_q, we_d;

  logic       grant_valid;
  requester_e grant_id;
  logic       grant;
  logic       in_xfer;
  logic       in_done;
  logic       own_d;
  logic       resp;
  logic       last_word;
  logic       timeout;
  logic       rvalid;
  logic       unused_ok;

  cache_mem_arb_rr u_rr (
    .req         ({d_req, i_req}),
    .last        (rr_last_q),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

  assign in_xfer   = (state_q == XFER);
  assign in_done   = (state_q == DONE);
  assign own_d     = (owner_q == REQ_D);
  assign grant     = (state_q == IDLE) && grant_valid;
  assign resp      = in_xfer && mem.mem_resp_valid;
  assign last_word =
    (widx_q == WORD_SEL_BITS'(WORDS_PER_LINE - 1));
  assign unused_ok =
    ^{i_addr[OFFSET_BITS-1:0], d_addr[OFFSET_BITS-1:0]};

`ifdef CACHE_MEM_ARB_TIMEOUT_EN
  localparam int unsigned CW =
    (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [CW-1:0] wdog_q, wdog_d;
  logic          err_q, err_d;

  // Watchdog: cleared by grant or response,
  // fires when it would reach the limit.
  always_comb begin
    wdog_d  = wdog_q;
    err_d   = err_q;
    timeout = 1'b0;
    if (grant) begin
      wdog_d = '0;
      err_d  = 1'b0;
    end else if (in_xfer) begin
      if (mem.mem_resp_valid) begin
        wdog_d = '0;
      end else begin
        wdog_d  = wdog_q + CW'(1);
        timeout =
          (wdog_d == CW'(TIMEOUT_CYCLES - 1));
        if (timeout) begin
          err_d = 1'b1;
        end
      end
    end
  end

  // Watchdog and abort-flag registers
  always_ff @(posedge clk) begin
    if (rst) begin
      wdog_q <= '0;
      err_q  <= 1'b0;
    end else begin
      wdog_q <= wdog_d;
      err_q  <= err_d;
    end
  end

  assign i_err = in_done && err_q && !own_d;
  assign d_err = in_done && err_q && own_d;
`else
  logic unused_tmo;

  assign timeout    = 1'b0;
  assign unused_tmo = TIMEOUT_CYCLES[0];
  assign i_err      = 1'b0;
  assign d_err      = 1'b0;
`endif

  // Grant, word sequencing and line completion
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    rr_last_d = rr_last_q;
    widx_d    = widx_q;
    line_d    = line_q;
    we_d      = we_q;
    unique case (state_q)
      IDLE: begin
        if (grant_valid) begin
          owner_d   = grant_id;
          rr_last_d = grant_id;
          widx_d    = '0;
          state_d   = XFER;
          if (grant_id == REQ_D) begin
            we_d   = d_we;
            line_d = d_addr[31:OFFSET_BITS];
          end else begin
            we_d   = i_we;
            line_d = i_addr[31:OFFSET_BITS];
          end
        end
      end
      XFER: begin
        if (resp) begin
          widx_d = widx_q + WORD_SEL_BITS'(1);
          if (last_word) begin
            state_d = DONE;
          end
        end else if (timeout) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Arbiter state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      owner_q   <= REQ_I;
      rr_last_q <= REQ_D;
      widx_q    <= '0;
      line_q    <= '0;
      we_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      rr_last_q <= rr_last_d;
      widx_q    <= widx_d;
      line_q    <= line_d;
      we_q      <= we_d;
    end
  end

  // Bus and requester-side outputs
  always_comb begin
    mem.mem_req   = in_xfer;
    mem.mem_we    = in_xfer && we_q;
    mem.mem_addr  = '0;
    mem.mem_wdata = own_d ? d_wdata : i_wdata;
    if (in_xfer) begin
      mem.mem_addr = {line_q, widx_q, 2'b00};
    end
    rvalid   = resp && !we_q;
    i_rvalid = rvalid && !own_d;
    d_rvalid = rvalid && own_d;
    i_done   = in_done && !own_d;
    d_done   = in_done && own_d;
    i_rdata  = mem.mem_rdata;
    d_rdata  = mem.mem_rdata;
    word_idx = widx_q;
  end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed bench for cache_mem_arbiter:
// per-cycle vector table plus corner sequences.
module tb_cache_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req, i_we, d_req, d_we;
  logic [31:0] i_addr, d_addr;
  logic [31:0] i_wdata, d_wdata;
  logic [31:0] i_rdata, d_rdata;
  logic        i_rvalid, d_rvalid;
  logic        i_done, d_done, i_err, d_err;
  logic [1:0]  word_idx;

  int n_vec = 0;
  int n_bad = 0;

  cache_mem_arbiter_if mem_if ();

  always #5 clk = ~clk;

  always_comb begin
    i_wdata = 32'h1000_0000 + {30'b0, word_idx};
    d_wdata = 32'hD000_0000 + {30'b0, word_idx};
  end

  cache_mem_arbiter #(
    .WORDS_PER_LINE (4),
    .WORD_SEL_BITS  (2),
    .OFFSET_BITS    (4),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .i_req    (i_req),
    .i_we     (i_we),
    .i_addr   (i_addr),
    .i_wdata  (i_wdata),
    .i_rdata  (i_rdata),
    .i_rvalid (i_rvalid),
    .i_done   (i_done),
    .i_err    (i_err),
    .d_req    (d_req),
    .d_we     (d_we),
    .d_addr   (d_addr),
    .d_wdata  (d_wdata),
    .d_rdata  (d_rdata),
    .d_rvalid (d_rvalid),
    .d_done   (d_done),
    .d_err    (d_err),
    .word_idx (word_idx),
    .mem      (mem_if)
  );

  typedef struct {
    logic        ir, iw, dr, dw, rv;
    logic [31:0] rd;
    logic        e_req, e_we;
    logic [31:0] e_addr, e_wd;
    logic        e_irv, e_drv, e_idn, e_ddn;
  } vec_t;

  vec_t tbl [23];

  function automatic vec_t v(
    input logic ir, iw, dr, dw, rv,
    input logic [31:0] rd,
    input logic e_req, e_we,
    input logic [31:0] e_addr, e_wd,
    input logic e_irv, e_drv, e_idn, e_ddn
  );
    vec_t r;
    r.ir = ir; r.iw = iw; r.dr = dr;
    r.dw = dw; r.rv = rv; r.rd = rd;
    r.e_req = e_req; r.e_we = e_we;
    r.e_addr = e_addr; r.e_wd = e_wd;
    r.e_irv = e_irv; r.e_drv = e_drv;
    r.e_idn = e_idn; r.e_ddn = e_ddn;
    return r;
  endfunction

  task automatic chk(
    input string nm,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h",
               nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string nm);
    chk({nm, " mem_req"}, mem_if.mem_req, 0);
    chk({nm, " mem_addr"}, mem_if.mem_addr, 0);
    chk({nm, " i_done"}, i_done, 0);
    chk({nm, " d_done"}, d_done, 0);
  endtask

  initial begin
    tbl[0]  = v(1,0,0,0,0,0,   0,0,0,0,                     0,0,0,0);
    tbl[1]  = v(1,0,0,0,0,0,   1,0,32'h1230,0,              0,0,0,0);
    tbl[2]  = v(1,0,0,0,0,0,   1,0,32'h1230,0,              0,0,0,0);
    tbl[3]  = v(1,0,0,0,1,'hA0,1,0,32'h1230,0,              1,0,0,0);
    tbl[4]  = v(1,0,0,0,0,0,   1,0,32'h1234,0,              0,0,0,0);
    tbl[5]  = v(1,0,0,0,0,0,   1,0,32'h1234,0,              0,0,0,0);
    tbl[6]  = v(1,0,0,0,1,'hA1,1,0,32'h1234,0,              1,0,0,0);
    tbl[7]  = v(1,0,0,0,0,0,   1,0,32'h1238,0,              0,0,0,0);
    tbl[8]  = v(1,0,0,0,0,0,   1,0,32'h1238,0,              0,0,0,0);
    tbl[9]  = v(1,0,0,0,1,'hA2,1,0,32'h1238,0,              1,0,0,0);
    tbl[10] = v(1,0,0,0,0,0,   1,0,32'h123C,0,              0,0,0,0);
    tbl[11] = v(1,0,0,0,0,0,   1,0,32'h123C,0,              0,0,0,0);
    tbl[12] = v(1,0,0,0,1,'hA3,1,0,32'h123C,0,              1,0,0,0);
    tbl[13] = v(1,0,0,0,0,0,   0,0,0,0,                     0,0,1,0);
    tbl[14] = v(0,0,0,0,1,'h55,0,0,0,0,                     0,0,0,0);
    tbl[15] = v(0,0,1,1,0,0,   0,0,0,0,                     0,0,0,0);
    tbl[16] = v(0,0,1,1,1,'h77,1,1,32'h8000_0040,32'hD000_0000,0,0,0,0);
    tbl[17] = v(0,0,1,1,1,'h77,1,1,32'h8000_0044,32'hD000_0001,0,0,0,0);
    tbl[18] = v(0,0,1,1,0,0,   1,1,32'h8000_0048,32'hD000_0002,0,0,0,0);
    tbl[19] = v(0,0,1,1,1,'h77,1,1,32'h8000_0048,32'hD000_0002,0,0,0,0);
    tbl[20] = v(0,0,1,1,1,'h77,1,1,32'h8000_004C,32'hD000_0003,0,0,0,0);
    tbl[21] = v(0,0,1,1,0,0,   0,0,0,0,                     0,0,0,1);
    tbl[22] = v(0,0,0,0,0,0,   0,0,0,0,                     0,0,0,0);

    rst = 1'b1;
    i_req = 0; i_we = 0; d_req = 0; d_we = 0;
    i_addr = 32'h0000_1234;
    d_addr = 32'h8000_0040;
    mem_if.mem_rdata = '0;
    mem_if.mem_resp_valid = 1'b0;
    step();
    step();
    chk_idle("reset");
    chk("reset mem_we", mem_if.mem_we, 0);
    chk("reset word_idx", word_idx, 0);
    chk("reset i_err", i_err, 0);
    chk("reset d_err", d_err, 0);
    chk("reset i_rvalid", i_rvalid, 0);
    rst = 1'b0;

    for (int r = 0; r < 23; r++) begin
      i_req = tbl[r].ir; i_we = tbl[r].iw;
      d_req = tbl[r].dr; d_we = tbl[r].dw;
      mem_if.mem_resp_valid = tbl[r].rv;
      mem_if.mem_rdata = tbl[r].rd;
      #1;
      chk($sformatf("row%0d mem_req", r), mem_if.mem_req, tbl[r].e_req);
      chk($sformatf("row%0d mem_we", r), mem_if.mem_we, tbl[r].e_we);
      chk($sformatf("row%0d mem_addr", r), mem_if.mem_addr, tbl[r].e_addr);
      if (tbl[r].e_req && tbl[r].e_we)
        chk($sformatf("row%0d mem_wdata", r), mem_if.mem_wdata, tbl[r].e_wd);
      chk($sformatf("row%0d i_rvalid", r), i_rvalid, tbl[r].e_irv);
      chk($sformatf("row%0d d_rvalid", r), d_rvalid, tbl[r].e_drv);
      if (tbl[r].e_irv)
        chk($sformatf("row%0d i_rdata", r), i_rdata, tbl[r].rd);
      chk($sformatf("row%0d i_done", r), i_done, tbl[r].e_idn);
      chk($sformatf("row%0d d_done", r), d_done, tbl[r].e_ddn);
      chk($sformatf("row%0d i_err", r), i_err, 0);
      chk($sformatf("row%0d d_err", r), d_err, 0);
      step();
    end

    // Tie from reset with zero-wait memory
    rst = 1'b1;
    step();
    rst = 1'b0;
    i_req = 1; d_req = 1; i_we = 0; d_we = 0;
    mem_if.mem_resp_valid = 1'b1;
    mem_if.mem_rdata = 32'hC0DE_0000;
    for (int c = 0; c < 18; c++) begin
      automatic int p = c % 6;
      automatic int q = c % 12;
      automatic logic e_req = (p >= 1) && (p <= 4);
      automatic logic own_i = (q < 6);
      automatic logic [31:0] base =
        own_i ? 32'h1230 : 32'h8000_0040;
      #1;
      chk($sformatf("tie c%0d mem_req", c), mem_if.mem_req, e_req);
      chk($sformatf("tie c%0d i_rvalid", c), i_rvalid, e_req && own_i);
      chk($sformatf("tie c%0d d_rvalid", c), d_rvalid, e_req && !own_i);
      chk($sformatf("tie c%0d i_done", c), i_done, q == 5);
      chk($sformatf("tie c%0d d_done", c), d_done, q == 11);
      if (e_req) begin
        chk($sformatf("tie c%0d word_idx", c), word_idx, p - 1);
        chk($sformatf("tie c%0d mem_addr", c), mem_if.mem_addr,
            base + 32'(4 * (p - 1)));
      end
      step();
    end

    // Reset in the middle of a line
    d_req = 0; i_req = 1;
    mem_if.mem_resp_valid = 1'b0;
    step();
    mem_if.mem_resp_valid = 1'b1;
    step();
    step();
    #1;
    chk("midrst word_idx", word_idx, 2);
    chk("midrst mem_addr", mem_if.mem_addr, 32'h1238);
    rst = 1'b1;
    mem_if.mem_resp_valid = 1'b0;
    step();
    rst = 1'b0;
    #1;
    chk_idle("after rst");
    chk("after rst word_idx", word_idx, 0);
    step();
    chk("restart mem_req", mem_if.mem_req, 1);
    chk("restart mem_addr", mem_if.mem_addr, 32'h1230);
    chk("restart word_idx", word_idx, 0);
    mem_if.mem_resp_valid = 1'b1;
    repeat (4) step();
    chk("restart i_done", i_done, 1);
    chk("restart mem_req end", mem_if.mem_req, 0);
    i_req = 0;
    mem_if.mem_resp_valid = 1'b0;
    step();
    chk_idle("restart idle");

`ifdef CACHE_MEM_ARB_TIMEOUT_EN
    // Watchdog abort with no responses
    i_req = 1;
    step();
    for (int k = 1; k <= 8; k++) begin
      #1;
      chk($sformatf("tmo k%0d mem_req", k), mem_if.mem_req, k < 8);
      chk($sformatf("tmo k%0d i_done", k), i_done, k == 8);
      chk($sformatf("tmo k%0d i_err", k), i_err, k == 8);
      if (k == 8) i_req = 0;
      step();
    end
    chk_idle("tmo idle");
`endif

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule
